// File: rtl/aes_output_interface.sv
// aes_output_interface: captures a finished ciphertext block from the round
// transformer, acknowledges it with a one-cycle output_read pulse, then
// streams it MSB-word-first over a valid/ready word interface.
// Optional build macro AES_OUT_LAST_EN adds the registered dout_last output.
// BLOCK_W must be an integer multiple of OUT_W.
module aes_output_interface #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic               engine_done,
  output logic               output_read,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               ready,
  output logic               overrun
`ifdef AES_OUT_LAST_EN
  ,
  output logic               dout_last
`endif
);

  localparam int unsigned NWORDS = BLOCK_W / OUT_W;
  localparam int unsigned CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               oread_q, oread_d;
  logic               dvalid_q, dvalid_d;
  logic               overrun_q, overrun_d;
`ifdef AES_OUT_LAST_EN
  logic               last_q, last_d;
`endif

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      oread_q   <= 1'b0;
      dvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef AES_OUT_LAST_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      oread_q   <= oread_d;
      dvalid_q  <= dvalid_d;
      overrun_q <= overrun_d;
`ifdef AES_OUT_LAST_EN
      last_q    <= last_d;
`endif
    end
  end

  // Next-state: capture on an armed done, shift out one word per handshake.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    oread_d   = 1'b0;
    dvalid_d  = dvalid_q;
    overrun_d = overrun_q;
    // Re-arm whenever done is seen low, so a held-high done captures only once.
    if (!engine_done) begin
      armed_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (engine_done && armed_q) begin
          shreg_d  = ciphertext;
          oread_d  = 1'b1;
          dvalid_d = 1'b1;
          cnt_d    = '0;
          armed_d  = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // A fresh done while busy is flagged but left armed, so it is
        // picked up once the current block drains.
        if (engine_done && armed_q) begin
          overrun_d = 1'b1;
        end
        if (dvalid_q && dout_ready) begin
          if (cnt_q == CNT_LAST) begin
            shreg_d  = '0;
            cnt_d    = '0;
            dvalid_d = 1'b0;
            state_d  = IDLE;
          end else begin
            shreg_d = shreg_q << OUT_W;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_OUT_LAST_EN
  // Last-word flag registered alongside valid so it holds through stalls.
  always_comb begin
    last_d = dvalid_d && (cnt_d == CNT_LAST);
  end
`endif

  // Outputs are straight register taps plus the idle decode.
  always_comb begin
    output_read = oread_q;
    dout        = shreg_q[BLOCK_W-1 -: OUT_W];
    dout_valid  = dvalid_q;
    ready       = (state_q == IDLE);
    overrun     = overrun_q;
`ifdef AES_OUT_LAST_EN
    dout_last   = last_q;
`endif
  end

endmodule

// File: doc/aes_output_interface.md
Name: aes_output_interface

Overview:
Downstream stage of the AES engine top level. Consumes the 128-bit ciphertext and done flag from the round transformer, captures the block, and acknowledges it with a one-cycle output_read pulse, which replaces the temporary top-level output_read input. It then streams the block out MSB-byte-first over a valid/ready byte interface, mirroring the byte-wide input interface.

Parameters:
BLOCK_W, 128, ciphertext width in bits.
OUT_W, 8, output word width in bits.
- BLOCK_W must be an integer multiple of OUT_W.
- NWORDS = BLOCK_W/OUT_W (16 at default).
- Counter width = $clog2(NWORDS).

Ports:
clk  input  1  system clock, rising edge
rst_  input  1  asynchronous, active-low reset
ciphertext  input  BLOCK_W  result from the round transformer; valid while engine_done is high
engine_done  input  1  transformer done flag (level)
output_read  output  1  one-cycle pulse: block captured; transformer may release the result
dout  output  OUT_W  current output word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  consumer accepts dout this cycle
ready  output  1  high in IDLE: no block in flight
overrun  output  1  sticky: a new done edge arrived while a block was in flight

Behaviour:
- Reset (rst_ low, asynchronous):
  - state=IDLE, shreg=0, cnt=0, armed=1.
  - output_read=0, dout=0, dout_valid=0, overrun=0, ready=1.
- All other logic is synchronous to the rising edge of clk.
- dout = shreg[BLOCK_W-1 -: OUT_W] (registered shift register top). ready = (state==IDLE).
- armed:
  - Set at any edge where engine_done is sampled 0.
  - Cleared on capture.
  - Result: one capture per done assertion, even if engine_done is held high.
- IDLE:
  - Capture condition: engine_done=1 and armed=1.
  - On capture: shreg<=ciphertext, output_read<=1, dout_valid<=1, cnt<=0, armed<=0, state<=SEND.
  - output_read and dout_valid rise together, 1 cycle after engine_done is sampled.
- SEND:
  - output_read<=0. It is high for exactly one cycle per capture.
  - Handshake = dout_valid & dout_ready.
  - On handshake with cnt<NWORDS-1: shreg<=shreg<<OUT_W, cnt<=cnt+1.
  - On handshake with cnt==NWORDS-1: shreg<=0, cnt<=0, dout_valid<=0, state<=IDLE.
  - With no handshake, dout and dout_valid hold (stall). No word is dropped or duplicated.
  - If engine_done is sampled 1 while armed=1: overrun<=1; no capture.
  - That pending block is captured after returning to IDLE, provided engine_done is still high and armed is still 1.
- Throughput:
  - At least one IDLE cycle between blocks.
  - With dout_ready held high: NWORDS consecutive valid cycles, minimum NWORDS+1 cycles per block.
- Boundaries:
  - dout_ready high while dout_valid is low: ignored.
  - engine_done dropping mid-transfer: no effect on the transfer (the data is already captured).
  - Reset mid-transfer: the partial block is discarded and all outputs return to reset values immediately.
  - overrun is cleared only by reset.

Optional Feature:
AES_OUT_LAST_EN:
- Defined:
  - Adds output port dout_last (1 bit, reset 0), registered.
  - dout_last is high exactly while dout_valid=1 and cnt==NWORDS-1, and holds through stalls.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_ low mid-clock -> all outputs 0 except ready=1, asynchronously without a clock edge.
- Stream: ciphertext=128'h69c4e0d86a7b0430d8cdb78070b4c55a, pulse engine_done, dout_ready=1 -> output_read high for 1 cycle; dout = 69,c4,e0,d8,...,c5,5a on 16 consecutive cycles; ready=1 on the 17th cycle; dout_last (if enabled) only on 5a.
- Backpressure: same block, dout_ready=1 only on alternate cycles and low for 5 cycles at byte 7 -> dout and dout_valid stable during stalls; byte sequence exact; 16 handshakes total.
- Held done: engine_done held high for 40 cycles -> exactly one output_read pulse, one 16-byte stream, overrun=0.
- Overrun: done low then high at byte 4 of the first block, second block=128'h3925841d02dc09fbdc118597196a0b32 -> overrun=1; first block completes; second block is captured in IDLE and streams 39,25,...,32.
- Reset mid-op: rst_ low during byte 5 -> outputs reset; next done -> full 16-byte stream from byte 0, overrun=0.
